// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and the iteration-state type shared by seq_alu
// and its multiply/divide engine.
package alu_pkg;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NEG = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10001;

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: signed radix-2 Booth multiplier / restoring divider, one bit per clock.
// The divider datapath is present only when SEQ_ALU_DIV_EN is defined.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2*WIDTH+2;

  // acc = {A/R (WIDTH+1), Q (WIDTH), q_-1}; the extra A bit absorbs +/- most-negative M
  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc, acc_nx;
  logic [WIDTH-1:0] m, q;
  logic [WIDTH:0]   a_cur, a_sum, m_ext;

  assign a_cur = acc[AW-1:WIDTH+1];
  assign q     = acc[WIDTH:1];
  assign m_ext = {m[WIDTH-1], m};

`ifdef SEQ_ALU_DIV_EN
  logic           div_q, neg_q, neg_r;
  logic [WIDTH:0] r_sh, r_dif;
  assign r_sh  = {a_cur[WIDTH-1:0], q[WIDTH-1]};
  assign r_dif = r_sh - {1'b0, m};
`else
  logic unused_div;
  assign unused_div = is_div;
`endif

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    fin      = (state == FIN);
    case (state)
      IDLE:    if (start) state_nx = ITER;
      ITER:    if (cnt == CW'(WIDTH-1)) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    case ({q[0], acc[0]})
      2'b01:   a_sum = a_cur + m_ext;
      2'b10:   a_sum = a_cur - m_ext;
      default: a_sum = a_cur;
    endcase
    acc_nx = {a_sum[WIDTH], a_sum, q};
`ifdef SEQ_ALU_DIV_EN
    if (div_q) begin
      if (r_dif[WIDTH]) acc_nx = {r_sh,  q[WIDTH-2:0], 2'b00};
      else              acc_nx = {r_dif, q[WIDTH-2:0], 2'b10};
    end
`endif
  end

  always_comb begin
    hi = acc[2*WIDTH:WIDTH+1];
    lo = q;
`ifdef SEQ_ALU_DIV_EN
    if (div_q) begin
      hi = neg_r ? -acc[2*WIDTH:WIDTH+1] : acc[2*WIDTH:WIDTH+1];
      lo = neg_q ? -q : q;
    end
`endif
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      m     <= '0;
`ifdef SEQ_ALU_DIV_EN
      div_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        cnt <= '0;
        acc <= {{(WIDTH+1){1'b0}}, ra, 1'b0};
        m   <= rb;
`ifdef SEQ_ALU_DIV_EN
        div_q <= is_div;
        neg_q <= ra[WIDTH-1] ^ rb[WIDTH-1];
        neg_r <= ra[WIDTH-1];
        if (is_div) begin
          acc <= {{(WIDTH+1){1'b0}}, (ra[WIDTH-1] ? -ra : ra), 1'b0};
          m   <= rb[WIDTH-1] ? -rb : rb;
        end
`endif
      end else if (state == ITER) begin
        acc <= acc_nx;
        cnt <= cnt + CW'(1);  // wraps back to 0 after the last iteration
      end
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU; single-cycle ops complete from idle, MUL/DIV run in alu_muldiv_iter.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise DIV decodes as an illegal opcode.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  output logic [WIDTH-1:0] zhi,
  output logic [WIDTH-1:0] zlo,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             zero
);
  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]   imm_hi, imm_lo, eng_hi, eng_lo;
  logic               imm_err, accept, go_iter, is_div, eng_fin;

  assign sh     = rb[SHW-1:0];
  assign dbl    = {ra, ra};
  assign accept = start && !busy;
  assign is_div = (opcode == OP_DIV);
`ifdef SEQ_ALU_DIV_EN
  assign go_iter = accept && (opcode == OP_MUL || (is_div && rb != '0));
`else
  assign go_iter = accept && (opcode == OP_MUL);
`endif

  always_comb begin
    imm_hi  = '0;
    imm_lo  = '0;
    imm_err = 1'b0;
    case (opcode)
      OP_ADD: imm_lo = ra + rb;
      OP_SUB: imm_lo = ra - rb;
      OP_SHR: imm_lo = ra >> sh;
      OP_SHL: imm_lo = ra << sh;
      OP_ROR: imm_lo = WIDTH'(dbl >> sh);
      OP_ROL: imm_lo = WIDTH'(dbl >> (WIDTH - int'(sh)));
      OP_AND: imm_lo = ra & rb;
      OP_OR:  imm_lo = ra | rb;
      OP_NEG: imm_lo = -ra;
      OP_NOT: imm_lo = ~ra;
      OP_MUL: ;
`ifdef SEQ_ALU_DIV_EN
      // only reaches the result registers when rb==0
      OP_DIV: begin
        imm_hi  = ra;
        imm_lo  = '1;
        imm_err = 1'b1;
      end
`endif
      default: imm_err = 1'b1;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clock   (clock),
    .clear_n (clear_n),
    .start   (go_iter),
    .is_div  (is_div),
    .ra      (ra),
    .rb      (rb),
    .busy    (busy),
    .fin     (eng_fin),
    .hi      (eng_hi),
    .lo      (eng_lo)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      zhi  <= '0;
      zlo  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      zero <= 1'b1;
    end else begin
      done <= 1'b0;
      if (eng_fin) begin
        zhi  <= eng_hi;
        zlo  <= eng_lo;
        err  <= 1'b0;
        zero <= (eng_lo == '0);
        done <= 1'b1;
      end else if (accept && !go_iter) begin
        zhi  <= imm_hi;
        zlo  <= imm_lo;
        err  <= imm_err;
        zero <= (imm_lo == '0);
        done <= 1'b1;
      end
    end
  end
endmodule
